rom_fetch_arbiter: RTL
======================

ROM_FETCH_ARBITER -- requirements
Module: rom_fetch_arbiter

Interface
REQ-001 SHALL have parameter RR, default 1; 1 = round-robin arbitration, 0 = fixed priority to port 0.
REQ-002 SHALL have parameter CNT_W, default 16; width of the per-port access counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports m0_req / m1_req, input, 1 each, read request, held until granted.
REQ-006 SHALL have ports m0_addr / m1_addr, input, 7 each, requested ROM byte address.
REQ-007 SHALL have ports m0_gnt / m1_gnt, output, 1 each, combinational grant; request accepted this cycle.
REQ-008 SHALL have ports m0_rvalid / m1_rvalid, output, 1 each, one-cycle pulse; read data valid.
REQ-009 SHALL have ports m0_rdata / m1_rdata, output, 8 each, registered read data.
REQ-010 SHALL have port rom_addr, output, 7, registered address to the 128x8 ROM.
REQ-011 SHALL have port rom_data, input, 8, combinational read data from the ROM for rom_addr.
REQ-012 SHALL have ports m0_count / m1_count, output, CNT_W each, granted-access counters.

Function
REQ-013 SHALL grant at most one port per cycle; gnt asserted only while that port's req is high.
REQ-014 RR=1: on simultaneous requests SHALL grant the port not granted most recently (last_q); last_q resets to 1, so port 0 wins first.
REQ-015 RR=0: on simultaneous requests SHALL always grant port 0.
REQ-016 Single requester SHALL be granted in the same cycle regardless of RR or last_q.
REQ-017 Stage 1: on grant SHALL register granted address into rom_addr, owner into sel_q, and set v_q=1; with no grant, v_q=0 and rom_addr holds its value.
REQ-018 Stage 2: when v_q=1 SHALL register rom_data into the owner's rdata and pulse that owner's rvalid for exactly one cycle; the other port's rdata holds.
REQ-019 Latency: grant in cycle N -> rvalid and rdata in cycle N+2; fixed, no stalls.
REQ-020 Throughput: one grant per cycle sustained; back-to-back grants return data in grant order.
REQ-021 Both rvalid outputs SHALL never be high in the same cycle.
REQ-022 A port with req held high SHALL be re-granted every cycle it wins arbitration; each grant is one independent access.
REQ-023 Each counter SHALL increment by 1 per grant to its port and saturate at all-ones without wrap.
REQ-024 Address 7'h7F SHALL be handled like any other address; no address wrap or increment is performed by this block.
REQ-025 Requester drops req before grant: no access, no counter change, last_q unchanged.

Reset
REQ-026 During reset SHALL drive m0_gnt=m1_gnt=0 and ignore requests.
REQ-027 On reset SHALL clear rom_addr=7'h00, m0_rdata=m1_rdata=8'h00, rvalids=0, v_q=0, sel_q=0, last_q=1, counters=0.
REQ-028 Reset mid-operation SHALL drop in-flight accesses: no rvalid issued for grants made before reset, including the grant cycle immediately preceding reset.
REQ-029 First grant is possible in the first cycle after reset deasserts.

Verification
REQ-030 Single read: ROM[0]=8'h86; m0_req=1, m0_addr=0 in cycle N -> m0_gnt=1 at N, m0_rvalid=1 and m0_rdata=8'h86 at N+2, m0_count=1.
REQ-031 Contention RR=1: both req held 4 cycles, m0_addr=0, m1_addr=1 -> grants alternate 0,1,0,1; rvalids alternate with rdata 8'h86/8'hAA; both counts=2.
REQ-032 Contention RR=0: both req held 3 cycles -> m0_gnt=1 every cycle, m1_gnt=0; m1_count=0, m0_count=3.
REQ-033 Streaming: m1 reads addresses 2,3,4,5 on consecutive cycles -> m1_rvalid high 4 consecutive cycles with 8'h96,8'hF0,8'h20,8'hFE.
REQ-034 Reset mid-flight: grant m0 at N, reset=1 at N+1 -> no rvalid at N+2, all outputs at reset values, count=0.
REQ-035 Saturation: CNT_W=2, m0 granted 5 times -> m0_count reaches 2'b11 and stays.

Source files
------------

// File: rtl/rom_fetch_arbiter.sv
// Two-port arbiter in front of a 128x8 combinational ROM with a fixed two-stage
// read pipeline (address register, then data register) and per-port access counters.
module rom_fetch_arbiter #(
  parameter int unsigned RR    = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req,
  input  logic [6:0]       m0_addr,
  input  logic             m1_req,
  input  logic [6:0]       m1_addr,
  output logic             m0_gnt,
  output logic             m1_gnt,
  output logic             m0_rvalid,
  output logic             m1_rvalid,
  output logic [7:0]       m0_rdata,
  output logic [7:0]       m1_rdata,
  output logic [6:0]       rom_addr,
  input  logic [7:0]       rom_data,
  output logic [CNT_W-1:0] m0_count,
  output logic [CNT_W-1:0] m1_count
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  port_t last_q;
  port_t sel_q;
  logic  v_q;

  // Port 0 wins contention in fixed-priority mode, or in round-robin mode when
  // port 1 was the most recent winner.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (m0_req && (!m1_req || (RR == 0) || (last_q == PORT1)))
        m0_gnt = 1'b1;
      else if (m1_req)
        m1_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
      sel_q    <= PORT0;
      v_q      <= 1'b0;
      last_q   <= PORT1;
    end else if (m0_gnt || m1_gnt) begin
      rom_addr <= m0_gnt ? m0_addr : m1_addr;
      sel_q    <= m0_gnt ? PORT0 : PORT1;
      v_q      <= 1'b1;
      last_q   <= m0_gnt ? PORT0 : PORT1;
    end else begin
      v_q      <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= v_q && (sel_q == PORT0);
      m1_rvalid <= v_q && (sel_q == PORT1);
      if (v_q && (sel_q == PORT0)) m0_rdata <= rom_data;
      if (v_q && (sel_q == PORT1)) m1_rdata <= rom_data;
    end
  end

  // Counters stop at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_count <= '0;
      m1_count <= '0;
    end else begin
      if (m0_gnt && (m0_count != '1)) m0_count <= m0_count + CNT_W'(1);
      if (m1_gnt && (m1_count != '1)) m1_count <= m1_count + CNT_W'(1);
    end
  end

endmodule
